enc_input_filter: RTL and testbench

ENC_INPUT_FILTER -- requirements
Module: enc_input_filter

---
 rtl/enc_pkg.sv | 15 +
 rtl/enc_filter_ch.sv | 88 ++++++++
 rtl/enc_input_filter.sv | 68 ++++++
 tb/tb_enc_input_filter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and default constants for the encoder/button input filter.
// Channel FSM states and glitch counter sizing live here so all files agree.
package enc_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_t;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 1000;
    localparam int GLITCH_W          = 8;
    localparam int GLITCH_MAX        = (1 << GLITCH_W) - 1;

endpackage

// File: rtl/enc_filter_ch.sv
// One filter channel: raw level synchronizer followed by a stable-time
// debounce FSM that only accepts levels held for STABLE_CYCLES clocks.
module enc_filter_ch
    import enc_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic change,
    output logic glitch
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    ch_state_t              state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   level_nxt;
    logic                   change_nxt;

    // Lines idle high, so the chain resets to 1 to avoid a spurious change after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            level  <= 1'b1;
            change <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            change <= change_nxt;
        end
    end

    // A level that drops back before the counter expires counts as one glitch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = level;
        change_nxt = 1'b0;
        glitch     = 1'b0;
        unique case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (sync_out != level) begin
                    state_nxt = ST_PENDING;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_PENDING: begin
                if (sync_out == level) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                    glitch    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = ST_STABLE;
                    cnt_nxt    = '0;
                    level_nxt  = sync_out;
                    change_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/enc_input_filter.sv
// Multi-channel encoder/button input filter with a shared saturating
// count of rejected pulses across all channels.
module enc_input_filter
    import enc_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     enc_raw,
    input  logic                glitch_clr,
    output logic [N_CH-1:0]     enc_filter,
    output logic [N_CH-1:0]     enc_change,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    if (N_CH < 1) begin : g_bad_nch
        $error("enc_input_filter: N_CH must be at least 1");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("enc_input_filter: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("enc_input_filter: STABLE_CYCLES must be at least 2");
    end

    localparam int SUM_W = GLITCH_W + $clog2(N_CH + 1);

    logic [N_CH-1:0]  glitch_ev;
    logic [SUM_W-1:0] glitch_sum;
    logic [SUM_W-1:0] glitch_total;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        enc_filter_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (enc_raw[i]),
            .level  (enc_filter[i]),
            .change (enc_change[i]),
            .glitch (glitch_ev[i])
        );
    end

    // Wide enough that counter plus all channels firing at once cannot overflow.
    always_comb begin
        glitch_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            glitch_sum = glitch_sum + SUM_W'(glitch_ev[i]);
        end
        glitch_total = glitch_sum + SUM_W'(glitch_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst || glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_total > SUM_W'(GLITCH_MAX)) begin
            glitch_cnt <= GLITCH_W'(GLITCH_MAX);
        end else begin
            glitch_cnt <= glitch_total[GLITCH_W-1:0];
        end
    end

endmodule

// File: tb/tb_enc_input_filter.sv
// Directed bench for enc_input_filter with a short stable time so that
// latency, glitch rejection and counter saturation are quick to reach.
module tb_enc_input_filter;

    logic       clk;
    logic       rst;
    logic [1:0] enc_raw;
    logic       glitch_clr;
    logic [1:0] enc_filter;
    logic [1:0] enc_change;
    logic [7:0] glitch_cnt;

    int checks;
    int errors;

    enc_input_filter #(
        .N_CH          (2),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enc_raw    (enc_raw),
        .glitch_clr (glitch_clr),
        .enc_filter (enc_filter),
        .enc_change (enc_change),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] raw, input logic clr);
        enc_raw    = raw;
        glitch_clr = clr;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        logic seen_change;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(2'b11, 1'b0);

        // Reset and idle-high steady state
        step(3);
        checkOutput("reset_filter", 32'(enc_filter), 32'h3);
        checkOutput("reset_change", 32'(enc_change), 32'h0);
        checkOutput("reset_glitch", 32'(glitch_cnt), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checkOutput("idle_filter", 32'(enc_filter), 32'h3);
            checkOutput("idle_change", 32'(enc_change), 32'h0);
        end
        checkOutput("idle_glitch", 32'(glitch_cnt), 32'h0);

        // Channel 0 falls and stays low: update exactly at edge 6
        applyStimulus(2'b10, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            checkOutput($sformatf("fall_filter_e%0d", k), 32'(enc_filter), (k >= 6) ? 32'h2 : 32'h3);
            checkOutput($sformatf("fall_change_e%0d", k), 32'(enc_change), (k == 6) ? 32'h1 : 32'h0);
        end
        checkOutput("fall_glitch", 32'(glitch_cnt), 32'h0);
        applyStimulus(2'b11, 1'b0);
        step(10);
        checkOutput("rise_filter", 32'(enc_filter), 32'h3);

        // Two-cycle low pulse on channel 0 is rejected and counted
        seen_change = 1'b0;
        applyStimulus(2'b10, 1'b0);
        step(1);
        seen_change |= |enc_change;
        step(1);
        seen_change |= |enc_change;
        applyStimulus(2'b11, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            seen_change |= |enc_change;
        end
        checkOutput("pulse2_filter", 32'(enc_filter), 32'h3);
        checkOutput("pulse2_change", 32'(seen_change), 32'h0);
        checkOutput("pulse2_glitch", 32'(glitch_cnt), 32'h1);
        applyStimulus(2'b11, 1'b1);
        step(1);
        applyStimulus(2'b11, 1'b0);
        checkOutput("clr_glitch", 32'(glitch_cnt), 32'h0);

        // Channel 1 alone changes, channel 0 untouched
        applyStimulus(2'b01, 1'b0);
        step(6);
        checkOutput("ch1_filter", 32'(enc_filter), 32'h1);
        checkOutput("ch1_change", 32'(enc_change), 32'h2);
        applyStimulus(2'b11, 1'b0);
        step(8);
        checkOutput("ch1_back", 32'(enc_filter), 32'h3);
        applyStimulus(2'b11, 1'b1);
        step(1);
        applyStimulus(2'b11, 1'b0);

        // Simultaneous three-cycle glitches on both channels, up to saturation
        seen_change = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(2'b00, 1'b0);
            step(3);
            seen_change |= |enc_change;
            applyStimulus(2'b11, 1'b0);
            step(5);
            seen_change |= |enc_change;
            if (i == 1)   checkOutput("both_glitch_1", 32'(glitch_cnt), 32'd2);
            if (i == 127) checkOutput("both_glitch_127", 32'(glitch_cnt), 32'd254);
            if (i == 128) checkOutput("both_glitch_128", 32'(glitch_cnt), 32'd255);
        end
        checkOutput("sat_glitch", 32'(glitch_cnt), 32'd255);
        checkOutput("sat_filter", 32'(enc_filter), 32'h3);
        checkOutput("sat_change", 32'(seen_change), 32'h0);

        // Clear coincides with a glitch event at edge 6
        applyStimulus(2'b00, 1'b0);
        step(3);
        applyStimulus(2'b11, 1'b0);
        step(2);
        checkOutput("clrcoin_before", 32'(glitch_cnt), 32'd255);
        applyStimulus(2'b11, 1'b1);
        step(1);
        applyStimulus(2'b11, 1'b0);
        checkOutput("clrcoin_glitch", 32'(glitch_cnt), 32'd0);
        step(3);
        checkOutput("clrcoin_after", 32'(glitch_cnt), 32'd0);

        // Reset in the middle of a pending transition, then a fresh change
        applyStimulus(2'b10, 1'b0);
        step(4);
        rst = 1'b1;
        step(1);
        checkOutput("midrst_filter", 32'(enc_filter), 32'h3);
        checkOutput("midrst_change", 32'(enc_change), 32'h0);
        checkOutput("midrst_glitch", 32'(glitch_cnt), 32'h0);
        step(1);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            checkOutput($sformatf("post_filter_e%0d", k), 32'(enc_filter), (k >= 6) ? 32'h2 : 32'h3);
            checkOutput($sformatf("post_change_e%0d", k), 32'(enc_change), (k == 6) ? 32'h1 : 32'h0);
        end
        checkOutput("post_glitch", 32'(glitch_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
